// File: rtl/npu_cube_booth_pp_gen.sv
// rtl/npu_cube_booth_pp_gen.sv - pipelined radix-4 Booth partial-product generator
// S1 registers operands plus Booth digit codes; S2 registers the formed rows.
module npu_cube_booth_pp_gen #(
  parameter int DWA              = 8,
  parameter int DWB              = 8,
  parameter int DWPPLEN          = 10,
  parameter int NPU_CUBE_MAC_NUM = 8,
  parameter int DWCNT            = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DWA*NPU_CUBE_MAC_NUM-1:0]     in_a,
  input  logic [DWB*NPU_CUBE_MAC_NUM-1:0]     in_b,
  input  logic                                in_is_signed,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DWPPLEN*NPU_CUBE_MAC_NUM-1:0] line0,
  output logic [DWPPLEN*NPU_CUBE_MAC_NUM-1:0] line1,
  output logic [DWPPLEN*NPU_CUBE_MAC_NUM-1:0] line2,
  output logic [DWPPLEN*NPU_CUBE_MAC_NUM-1:0] line3,
  output logic [4*NPU_CUBE_MAC_NUM-1:0]       pp_neg,
  output logic [DWA*NPU_CUBE_MAC_NUM-1:0]     line4,
  output logic                                is_signed,
  output logic [DWCNT-1:0]                    beat_cnt
);

  localparam int N    = NPU_CUBE_MAC_NUM;
  localparam int ROWS = DWB / 2;
  localparam int EXT  = DWPPLEN - DWA;

  logic                     s1_valid_q;
  logic                     s2_valid_q;
  logic                     s1_load;
  logic                     s2_load;
  logic [DWA*N-1:0]         s1_a_q;
  logic [DWB*N-1:0]         s1_b_q;
  logic                     s1_signed_q;
  logic [3*ROWS*N-1:0]      s1_code_d;
  logic [3*ROWS*N-1:0]      s1_code_q;
  logic [DWPPLEN*N-1:0]     row_d [ROWS];
  logic [DWPPLEN*N-1:0]     row_q [ROWS];
  logic [ROWS*N-1:0]        neg_d;
  logic [ROWS*N-1:0]        neg_q;
  logic [DWA*N-1:0]         l4_d;
  logic [DWA*N-1:0]         l4_q;
  logic                     s2_signed_q;
  logic [DWCNT-1:0]         cnt_q;

  logic [DWB:0]             bext;
  logic [DWA-1:0]           a_lane;
  logic [DWPPLEN-1:0]       ax;
  logic [DWPPLEN-1:0]       mag;
  logic [2:0]               code;

  // A stage may load when empty or when its occupant leaves this cycle.
  assign s2_load  = ~s2_valid_q | out_ready;
  assign s1_load  = ~s1_valid_q | s2_load;
  assign in_ready = s1_load;

  // Digit code: [2]=negate, [1:0]=00 zero, 01 x1, 10 x2; triplet 111 is a plain zero.
  always_comb begin
    s1_code_d = '0;
    bext      = '0;
    for (int i = 0; i < N; i++) begin
      bext = {in_b[i*DWB +: DWB], 1'b0};
      for (int k = 0; k < ROWS; k++) begin
        case (bext[2*k +: 3])
          3'b001, 3'b010: s1_code_d[(i*ROWS+k)*3 +: 3] = 3'b001;
          3'b011:         s1_code_d[(i*ROWS+k)*3 +: 3] = 3'b010;
          3'b100:         s1_code_d[(i*ROWS+k)*3 +: 3] = 3'b110;
          3'b101, 3'b110: s1_code_d[(i*ROWS+k)*3 +: 3] = 3'b101;
          default:        s1_code_d[(i*ROWS+k)*3 +: 3] = 3'b000;
        endcase
      end
    end
  end

  // Negative rows are emitted as one's complement; the +1 travels on pp_neg.
  always_comb begin
    for (int k = 0; k < ROWS; k++) begin
      row_d[k] = '0;
    end
    neg_d  = '0;
    l4_d   = '0;
    a_lane = '0;
    ax     = '0;
    mag    = '0;
    code   = '0;
    for (int i = 0; i < N; i++) begin
      a_lane = s1_a_q[i*DWA +: DWA];
      ax     = {{EXT{a_lane[DWA-1] & s1_signed_q}}, a_lane};
      for (int k = 0; k < ROWS; k++) begin
        code = s1_code_q[(i*ROWS+k)*3 +: 3];
        if (code[1]) begin
          mag = {ax[DWPPLEN-2:0], 1'b0};
        end else if (code[0]) begin
          mag = ax;
        end else begin
          mag = '0;
        end
        row_d[k][i*DWPPLEN +: DWPPLEN] = code[2] ? ~mag : mag;
        neg_d[i*ROWS+k]                = code[2];
      end
      // Booth reads an unsigned B with its top bit set as negative; add A*2^DWB back.
      if (!s1_signed_q && s1_b_q[i*DWB+DWB-1]) begin
        l4_d[i*DWA +: DWA] = a_lane;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_signed_q <= 1'b0;
      s1_code_q   <= '0;
      for (int k = 0; k < ROWS; k++) begin
        row_q[k] <= '0;
      end
      neg_q       <= '0;
      l4_q        <= '0;
      s2_signed_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_a_q      <= in_a;
          s1_b_q      <= in_b;
          s1_signed_q <= in_is_signed;
          s1_code_q   <= s1_code_d;
        end
      end
      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          for (int k = 0; k < ROWS; k++) begin
            row_q[k] <= row_d[k];
          end
          neg_q       <= neg_d;
          l4_q        <= l4_d;
          s2_signed_q <= s1_signed_q;
        end
      end
      if (s2_valid_q && out_ready) begin
        cnt_q <= cnt_q + DWCNT'(1);
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign line0     = row_q[0];
  assign line1     = row_q[1];
  assign line2     = row_q[2];
  assign line3     = row_q[3];
  assign pp_neg    = neg_q;
  assign line4     = l4_q;
  assign is_signed = s2_signed_q;
  assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_npu_cube_booth_pp_gen.sv
// tb/tb_npu_cube_booth_pp_gen.sv - scoreboard bench for the Booth partial-product generator
module tb_npu_cube_booth_pp_gen;

  localparam int DWA = 8;
  localparam int DWB = 8;
  localparam int DWP = 10;
  localparam int N   = 8;
  localparam int DWC = 16;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sgn;
    logic        has_rows;
    logic [9:0]  l0, l1, l2, l3;
    logic [3:0]  neg;
    logic [7:0]  l4;
    longint      sum0;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [63:0]    in_a = '0;
  logic [63:0]    in_b = '0;
  logic           in_is_signed = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [79:0]    line0, line1, line2, line3;
  logic [31:0]    pp_neg;
  logic [63:0]    line4;
  logic           is_signed;
  logic [DWC-1:0] beat_cnt;

  int    checks = 0;
  int    errors = 0;
  int    xfers = 0;
  bit    rnd_ready = 0;
  bit    sent_done = 0;
  beat_t sb[$];

  npu_cube_booth_pp_gen #(
    .DWA(DWA), .DWB(DWB), .DWPPLEN(DWP), .NPU_CUBE_MAC_NUM(N), .DWCNT(DWC)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_is_signed(in_is_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .line0(line0), .line1(line1), .line2(line2), .line3(line3),
    .pp_neg(pp_neg), .line4(line4), .is_signed(is_signed), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint recon(input int lane);
    longint            s;
    logic signed [9:0] r;
    logic [79:0]       ln [4];
    ln[0] = line0; ln[1] = line1; ln[2] = line2; ln[3] = line3;
    s = 0;
    for (int k = 0; k < 4; k++) begin
      r = ln[k][lane*DWP +: DWP];
      s += (longint'(r) + longint'(pp_neg[lane*4+k])) * (longint'(1) << (2*k));
    end
    s += longint'(line4[lane*DWA +: DWA]) * 256;
    return s;
  endfunction

  function automatic longint model(input logic [7:0] a, input logic [7:0] b, input logic sgn);
    logic signed [7:0] sa;
    logic signed [7:0] sb8;
    sa  = a;
    sb8 = b;
    return sgn ? longint'(sa) * longint'(sb8) : longint'(a) * longint'(b);
  endfunction

  function automatic beat_t mk(input logic [7:0] a0, input logic [7:0] b0, input logic sgn,
                               input logic [9:0] l0, input logic [9:0] l1, input logic [9:0] l2,
                               input logic [9:0] l3, input logic [3:0] neg, input logic [7:0] l4,
                               input longint sum0);
    beat_t bt;
    bt.a = {56'h0, a0}; bt.b = {56'h0, b0}; bt.sgn = sgn; bt.has_rows = 1'b1;
    bt.l0 = l0; bt.l1 = l1; bt.l2 = l2; bt.l3 = l3; bt.neg = neg; bt.l4 = l4; bt.sum0 = sum0;
    return bt;
  endfunction

  function automatic beat_t mk_plain(input logic [63:0] a, input logic [63:0] b, input logic sgn);
    beat_t bt;
    bt = mk(8'h0, 8'h0, sgn, '0, '0, '0, '0, '0, '0, 0);
    bt.a = a; bt.b = b; bt.has_rows = 1'b0;
    return bt;
  endfunction

  task automatic send(input beat_t bt);
    int t;
    in_valid = 1'b1; in_a = bt.a; in_b = bt.b; in_is_signed = bt.sgn;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(bt);
        @(posedge clk);
        #1 in_valid = 1'b0;
        return;
      end
      t++;
      if (t > 500) begin
        chk("send_timeout", 64'(t), 0);
        in_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b0;
    sb.delete();
    xfers = 0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((sb.size() != 0 || !sent_done) && t < 5000) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    #1 chk(name, 64'(sb.size()), 0);
  endtask

  // Monitor: pops on every output transfer and checks held outputs under backpressure.
  initial begin
    logic [416:0] snap;
    bit           stall_prev;
    beat_t        bt;
    stall_prev = 0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 0;
      end else begin
        if (out_valid && stall_prev)
          chk("hold", 64'({line0, line1, line2, line3, pp_neg, line4, is_signed} == snap), 1);
        stall_prev = out_valid && !out_ready;
        snap = {line0, line1, line2, line3, pp_neg, line4, is_signed};
        if (out_valid && out_ready) begin
          xfers++;
          if (sb.size() == 0) begin
            chk("unexpected_out", 1, 0);
          end else begin
            bt = sb.pop_front();
            chk("is_signed", 64'(is_signed), 64'(bt.sgn));
            if (bt.has_rows) begin
              chk("line0", 64'(line0[9:0]), 64'(bt.l0));
              chk("line1", 64'(line1[9:0]), 64'(bt.l1));
              chk("line2", 64'(line2[9:0]), 64'(bt.l2));
              chk("line3", 64'(line3[9:0]), 64'(bt.l3));
              chk("pp_neg", 64'(pp_neg[3:0]), 64'(bt.neg));
              chk("line4", 64'(line4[7:0]), 64'(bt.l4));
            end
            for (int i = 0; i < N; i++) begin
              if (bt.has_rows && i == 0)
                chk("recon_dir", recon(0), bt.sum0);
              else
                chk($sformatf("recon_l%0d", i), recon(i),
                    model(bt.a[i*8 +: 8], bt.b[i*8 +: 8], bt.sgn));
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t bt;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_beat_cnt", 64'(beat_cnt), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_line0", line0[63:0], 0);

    // Directed: signed 3 * -1 with latency check
    bt = mk(8'h03, 8'hFF, 1'b1, 10'h3FC, 10'h0, 10'h0, 10'h0, 4'b0001, 8'h00, -3);
    in_valid = 1'b1; in_a = bt.a; in_b = bt.b; in_is_signed = bt.sgn;
    @(negedge clk);
    chk("in_ready_first", 64'(in_ready), 1);
    sb.push_back(bt);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("lat_after_s1", 64'(out_valid), 0);
    @(posedge clk);
    #1 chk("lat_after_s2", 64'(out_valid), 1);

    send(mk(8'h03, 8'hFF, 1'b0, 10'h3FC, 10'h0, 10'h0, 10'h0, 4'b0001, 8'h03, 765));
    send(mk(8'h80, 8'h02, 1'b1, 10'h0FF, 10'h380, 10'h0, 10'h0, 4'b0001, 8'h00, -256));
    send(mk(8'hFF, 8'h80, 1'b0, 10'h0, 10'h0, 10'h0, 10'h201, 4'b1000, 8'hFF, 32640));
    sent_done = 1;
    drain("drain_directed");
    chk("cnt_directed", 64'(beat_cnt), 4);

    // Backpressure: six beats against a stalled output
    do_reset();
    out_ready = 1'b0;
    sent_done = 0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(mk_plain({8'(i*7+1), 48'h0, 8'(i+1)}, {8'(8'hF0 + i), 48'h0, 8'(i*37+2)}, i[0]));
        sent_done = 1;
      end
    join_none
    repeat (6) @(posedge clk);
    #1;
    chk("stall_in_ready", 64'(in_ready), 0);
    chk("stall_accepted", 64'(sb.size()), 2);
    chk("stall_out_valid", 64'(out_valid), 1);
    out_ready = 1'b1;
    drain("drain_stall");
    chk("cnt_stall", 64'(beat_cnt), 6);
    chk("xfer_stall", 64'(xfers), 6);

    // Random operands, random backpressure
    do_reset();
    sent_done = 0;
    rnd_ready = 1;
    for (int i = 0; i < 1000; i++)
      send(mk_plain({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1))));
    sent_done = 1;
    rnd_ready = 0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain("drain_random");
    chk("cnt_random", 64'(beat_cnt), 64'(xfers[15:0]));
    chk("xfer_random", 64'(xfers), 1000);

    // Reset with both stages occupied
    do_reset();
    out_ready = 1'b0;
    send(mk_plain(64'h11, 64'h22, 1'b0));
    send(mk_plain(64'h33, 64'h44, 1'b1));
    #1;
    chk("full_in_ready", 64'(in_ready), 0);
    chk("full_out_valid", 64'(out_valid), 1);
    do_reset();
    chk("midrst_out_valid", 64'(out_valid), 0);
    chk("midrst_beat_cnt", 64'(beat_cnt), 0);
    chk("midrst_in_ready", 64'(in_ready), 1);
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_stale", 64'(xfers), 0);
    chk("midrst_cnt_after", 64'(beat_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
